// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and flag indices for alu_seq
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL1 = 4'b0110;
  localparam logic [3:0] OP_SHR1 = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBB  = 4'b1001;
  localparam logic [3:0] OP_SHLN = 4'b1010;
  localparam logic [3:0] OP_SHRN = 4'b1011;
  localparam logic [3:0] OP_ASRN = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_CMP  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_nshift(input logic [3:0] code);
    return (code == OP_SHLN) || (code == OP_SHRN) || (code == OP_ASRN);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - single-cycle ops and their {z,n,c,v} flags
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] zn_src;
  logic             cf;
  logic             vf;
  logic             rsv;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
    diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) & ~cin};
    res    = '0;
    cf     = 1'b0;
    vf     = 1'b0;
    rsv    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        res = sum[M:0];
        cf  = sum[WIDTH];
        vf  = (a[M] == b[M]) & (sum[M] != a[M]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res = (op == OP_CMP) ? a : diff[M:0];
        cf  = ~diff[WIDTH];
        vf  = (a[M] != b[M]) & (diff[M] != a[M]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL1: begin
        res = {a[M-1:0], 1'b0};
        cf  = a[M];
      end
      OP_SHR1: begin
        res = {1'b0, a[M:1]};
        cf  = a[0];
      end
      default: rsv = 1'b1;
    endcase
    // CMP reports the subtraction's z/n while passing a through
    zn_src = (op == OP_CMP) ? diff[M:0] : res;
    flags  = rsv ? 4'b0000 : {zn_src == '0, zn_src[M], cf, vf};
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU; ALU_SEQ_MUL_EN enables iterative MUL
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic [3:0]       flags_q
);

  localparam int M  = WIDTH - 1;
  localparam int CW = SW + 1;

  state_t           state, state_nx;
  logic             accept;
  logic             go_exec;
  logic [SW-1:0]    amt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] comb_res;
  logic [3:0]       comb_flags;
  logic [WIDTH-1:0] shifted;
  logic             shout;
  logic [WIDTH-1:0] exec_res;
  logic [3:0]       exec_flags;
  logic             last_step;

  assign amt       = b[SW-1:0];
  assign accept    = in_valid & in_ready;
  assign last_step = (state == EXEC) && (cnt == CW'(1));
  assign out       = out_r;
  assign {z, n, c, v} = flags_q;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod_nx;
  logic               mul_hi;

  assign go_exec = (is_nshift(op) && amt != '0) || (op == OP_MUL);
  assign prod_nx = prod + (work[0] ? mcand : '0);
  assign mul_hi  = |prod_nx[2*WIDTH-1:WIDTH];
`else
  assign go_exec = is_nshift(op) && amt != '0;
`endif

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (flags_q[FLAG_C]),
    .res   (comb_res),
    .flags (comb_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = go_exec ? EXEC : DONE;
      end
      EXEC: if (cnt == CW'(1)) state_nx = DONE;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (accept)         state_nx = go_exec ? EXEC : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One-bit step of the iterative shifter; shout is the bit leaving the word
  always_comb begin
    shifted = work;
    shout   = 1'b0;
    case (op_q)
      OP_SHLN: begin shifted = {work[M-1:0], 1'b0}; shout = work[M]; end
      OP_SHRN: begin shifted = {1'b0, work[M:1]};   shout = work[0]; end
      OP_ASRN: begin shifted = {work[M], work[M:1]}; shout = work[0]; end
      default: ;
    endcase
    exec_res   = shifted;
    exec_flags = {shifted == '0, shifted[M], shout, 1'b0};
`ifdef ALU_SEQ_MUL_EN
    if (op_q == OP_MUL) begin
      exec_res   = prod_nx[M:0];
      exec_flags = {prod_nx[M:0] == '0, prod_nx[M], mul_hi, mul_hi};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      work    <= '0;
      cnt     <= '0;
      out_r   <= '0;
      flags_q <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
      prod    <= '0;
      mcand   <= '0;
`endif
    end else if (accept) begin
      op_q <= op;
      if (go_exec) begin
        work <= a;
        cnt  <= {1'b0, amt};
`ifdef ALU_SEQ_MUL_EN
        if (op == OP_MUL) begin
          work  <= b;
          mcand <= {{WIDTH{1'b0}}, a};
          prod  <= '0;
          cnt   <= CW'(WIDTH);
        end
`endif
      end else if (is_nshift(op)) begin
        out_r   <= a;
        flags_q <= {a == '0, a[M], 1'b0, 1'b0};
      end else begin
        out_r   <= comb_res;
        flags_q <= comb_flags;
      end
    end else if (state == EXEC) begin
      cnt  <= cnt - 1'b1;
      work <= shifted;
`ifdef ALU_SEQ_MUL_EN
      if (op_q == OP_MUL) begin
        prod  <= prod_nx;
        mcand <= {mcand[2*WIDTH-2:0], 1'b0};
        work  <= {1'b0, work[M:1]};
      end
`endif
      if (last_step) begin
        out_r   <= exec_res;
        flags_q <= exec_flags;
      end
    end
  end

endmodule
